// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point flag/class types and constant helpers
package fp_pkg;

    localparam int FP_MAX_W = 128;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp_cls_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive infinity pattern, right-aligned in a FP_MAX_W word
    function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
        return ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_nan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (FP_MAX_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mult_round.sv
// rtl/fp_mult_round.sv - S3 normalize/round/pack/flag; FP_MULT_RNE_EN selects RNE, else truncate
module fp_mult_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       i_sign,
    input  fp_cls_t                    i_cls,
    input  logic signed [EXP_W+1:0]    i_exp,
    input  logic [2*MAN_W+1:0]         i_prod,
    output logic [EXP_W+MAN_W:0]       o_p,
    output fp_flags_t                  o_flags
);

    localparam int XW = EXP_W + 2;
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam logic [FP_MAX_W-1:0] L_NAN_FULL = fp_nan(EXP_W, MAN_W);
    localparam logic [FP_MAX_W-1:0] L_INF_FULL = fp_inf(EXP_W, MAN_W);
    localparam logic [W-1:0]        L_NAN      = L_NAN_FULL[W-1:0];
    localparam logic [W-2:0]        L_INF_MAG  = L_INF_FULL[W-2:0];
    localparam logic signed [XW-1:0] L_EMAX    = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] L_EMIN    = XW'(1);
`ifdef FP_MULT_RNE_EN
    localparam logic L_RNE = 1'b1;
`else
    localparam logic L_RNE = 1'b0;
`endif

    logic                  w_msb;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_up;
    logic                  w_carry;
    logic [MAN_W-1:0]      w_frac;
    logic [MAN_W:0]        w_rnd;
    logic signed [XW-1:0]  w_exp_n;
    logic signed [XW-1:0]  w_exp_f;

    // Product of two [1,2) significands lies in [1,4); MSB set means shift right by one
    assign w_msb    = i_prod[2*MAN_W+1];
    assign w_frac   = w_msb ? i_prod[2*MAN_W:MAN_W+1] : i_prod[2*MAN_W-1:MAN_W];
    assign w_guard  = w_msb ? i_prod[MAN_W] : i_prod[MAN_W-1];
    assign w_sticky = w_msb ? |i_prod[MAN_W-1:0] : |i_prod[MAN_W-2:0];

    assign w_up    = L_RNE & w_guard & (w_sticky | w_frac[0]);
    assign w_rnd   = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_up};
    assign w_carry = w_rnd[MAN_W];
    assign w_exp_n = i_exp + {{(XW-1){1'b0}}, w_msb};
    assign w_exp_f = w_exp_n + {{(XW-1){1'b0}}, w_carry};

    always_comb begin
        o_p     = '0;
        o_flags = '0;
        case (i_cls)
            CLS_NAN: begin
                o_p             = L_NAN;
                o_flags.invalid = 1'b1;
            end
            CLS_INF:  o_p = {i_sign, L_INF_MAG};
            CLS_ZERO: o_p = {i_sign, {(W-1){1'b0}}};
            default: begin
                if (w_exp_f >= L_EMAX) begin
                    o_p              = {i_sign, L_INF_MAG};
                    o_flags.overflow = 1'b1;
                end else if (w_exp_f < L_EMIN) begin
                    o_p               = {i_sign, {(W-1){1'b0}}};
                    o_flags.underflow = 1'b1;
                end else begin
                    o_p = {i_sign, w_exp_f[EXP_W-1:0], w_rnd[MAN_W-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage pipelined FP multiplier with global-advance handshake; FP_MULT_RNE_EN selects RNE
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_p,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = fp_bias(EXP_W);
    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam logic [XW-1:0] L_BIAS_X = XW'(BIAS);

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    fp_cls_t          w_cls;
    logic [XW-1:0]    w_exp_sum;
    logic             w_adv;
    logic [PW-1:0]    w_prod;
    logic [W-1:0]     w_p;
    fp_flags_t        w_flags;

    logic                  r1_valid, r1_sign;
    fp_cls_t               r1_cls;
    logic signed [XW-1:0]  r1_exp;
    logic [MAN_W:0]        r1_sig_a, r1_sig_b;
    logic [TAG_W-1:0]      r1_tag;

    logic                  r2_valid, r2_sign;
    fp_cls_t               r2_cls;
    logic signed [XW-1:0]  r2_exp;
    logic [PW-1:0]         r2_prod;
    logic [TAG_W-1:0]      r2_tag;

    logic                  r3_valid;
    logic [W-1:0]          r3_p;
    fp_flags_t             r3_flags;
    logic [TAG_W-1:0]      r3_tag;

    assign w_ea = in_a[W-2:MAN_W];
    assign w_eb = in_b[W-2:MAN_W];
    assign w_fa = in_a[MAN_W-1:0];
    assign w_fb = in_b[MAN_W-1:0];

    // Zero exponent covers subnormals too: they are flushed to signed zero
    assign w_nan_a  = (&w_ea) & (|w_fa);
    assign w_nan_b  = (&w_eb) & (|w_fb);
    assign w_inf_a  = (&w_ea) & ~(|w_fa);
    assign w_inf_b  = (&w_eb) & ~(|w_fb);
    assign w_zero_a = ~(|w_ea);
    assign w_zero_b = ~(|w_eb);

    always_comb begin
        if (w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b))
            w_cls = CLS_NAN;
        else if (w_inf_a | w_inf_b)
            w_cls = CLS_INF;
        else if (w_zero_a | w_zero_b)
            w_cls = CLS_ZERO;
        else
            w_cls = CLS_NORM;
    end

    assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - L_BIAS_X;
    assign w_prod    = PW'(r1_sig_a) * PW'(r1_sig_b);

    // Every stage moves together unless a finished result is stuck at the output
    assign w_adv    = !r3_valid || out_ready;
    assign in_ready = w_adv;

    fp_mult_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign  (r2_sign),
        .i_cls   (r2_cls),
        .i_exp   (r2_exp),
        .i_prod  (r2_prod),
        .o_p     (w_p),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_cls   <= CLS_NORM;
            r1_exp   <= '0;
            r1_sig_a <= '0;
            r1_sig_b <= '0;
            r1_tag   <= '0;
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_cls   <= CLS_NORM;
            r2_exp   <= '0;
            r2_prod  <= '0;
            r2_tag   <= '0;
            r3_valid <= 1'b0;
            r3_p     <= '0;
            r3_flags <= '0;
            r3_tag   <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_sign  <= in_a[W-1] ^ in_b[W-1];
            r1_cls   <= w_cls;
            r1_exp   <= w_exp_sum;
            r1_sig_a <= {1'b1, w_fa};
            r1_sig_b <= {1'b1, w_fb};
            r1_tag   <= in_tag;
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_cls   <= r1_cls;
            r2_exp   <= r1_exp;
            r2_prod  <= w_prod;
            r2_tag   <= r1_tag;
            r3_valid <= r2_valid;
            r3_p     <= w_p;
            r3_flags <= w_flags;
            r3_tag   <= r2_tag;
        end
    end

    assign out_valid = r3_valid;
    assign out_p     = r3_p;
    assign out_tag   = r3_tag;
    assign out_flags = r3_flags;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - self-checking bench for fp_mult_pipe (default EXP_W=8, MAN_W=23)
`timescale 1ns/1ps
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;
    logic [3:0]  out_tag;
    logic [2:0]  out_flags;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [2:0]  f;
    } vec_t;

`ifdef FP_MULT_RNE_EN
    localparam logic [31:0] RND_TIE   = 32'h3FC00002;
    localparam logic [31:0] RND_CARRY = 32'h40000000;
`else
    localparam logic [31:0] RND_TIE   = 32'h3FC00001;
    localparam logic [31:0] RND_CARRY = 32'h3FFFFFFF;
`endif

    int          n_checks = 0;
    int          n_pass = 0;
    int          accepts = 0;
    logic [38:0] sb[$];
    logic [3:0]  got_tags[$];
    logic [34:0] mon_r;
    vec_t        vecs[12];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference: exact product in double precision, then rounded/classified from the IEEE rules
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        bit          na, nb, ia, ib, za, zb, g, st, up;
        real         pr;
        logic [63:0] bits;
        logic [51:0] m;
        logic [23:0] f;
        int          e;
        bit          rne;
`ifdef FP_MULT_RNE_EN
        rne = 1'b1;
`else
        rne = 1'b0;
`endif
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        na = (ea == 8'hFF) && (fa != 0);
        nb = (eb == 8'hFF) && (fb != 0);
        ia = (ea == 8'hFF) && (fa == 0);
        ib = (eb == 8'hFF) && (fb == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb || (ia && zb) || (za && ib)) return {32'h7FC00000, 3'b100};
        if (ia || ib) return {s, 31'h7F800000, 3'b000};
        if (za || zb) return {s, 31'h0, 3'b000};
        pr   = real'(int'({8'h00, 1'b1, fa})) * real'(int'({8'h00, 1'b1, fb}));
        bits = $realtobits(pr);
        e    = int'(ea) + int'(eb) - 127 + (int'(bits[62:52]) - 1023 - 46);
        m    = bits[51:0];
        f    = {1'b0, m[51:29]};
        g    = m[28];
        st   = |m[27:0];
        up   = rne && g && (st || f[0]);
        f    = f + 24'(up);
        if (f[23]) begin
            f = '0;
            e++;
        end
        if (e >= 255) return {s, 31'h7F800000, 3'b010};
        if (e <= 0) return {s, 31'h0, 3'b001};
        return {s, 8'(e), f[22:0], 3'b000};
    endfunction

    // Single compare process: every valid output cycle must match the oldest outstanding model result
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                chk(sb.size() > 0, "out_without_accept", 64'(sb.size()), 1);
                if (sb.size() > 0) begin
                    chk({out_p, out_flags, out_tag} == sb[0], "sb_result",
                        {25'h0, out_p, out_flags, out_tag}, {25'h0, sb[0]});
                    if (out_ready) begin
                        got_tags.push_back(out_tag);
                        void'(sb.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_r = model(in_a, in_b);
                sb.push_back({mon_r, in_tag});
                accepts++;
            end
        end
    end

    task automatic run_one(input vec_t v, input logic [3:0] tag, input string nm);
        int n;
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n == 3, {nm, "_latency"}, 64'(n), 3);
        chk(out_p == v.p, {nm, "_p"}, 64'(out_p), 64'(v.p));
        chk(out_flags == v.f, {nm, "_flags"}, 64'(out_flags), 64'(v.f));
        @(posedge clk); #1;
    endtask

    task automatic push_ops(input int start, input int n, input logic [15:0] rdy_pat,
                            input bit use_pat, input int max_cyc, output int acc_cnt);
        int idx;
        int c;
        bit took;
        idx = start; c = 0; acc_cnt = 0;
        while (idx < start + n && c < max_cyc) begin
            if (use_pat) out_ready = rdy_pat[c % 16];
            in_valid = 1'b1;
            in_a = vecs[idx % 12].a; in_b = vecs[idx % 12].b; in_tag = 4'(idx);
            #2;
            took = in_ready;
            @(posedge clk); #1;
            if (took) begin
                idx++;
                acc_cnt++;
            end
            c++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk(sb.size() == 0, nm, 64'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int base;
        int stale;
        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
        vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
        vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
        vecs[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
        vecs[4]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
        vecs[5]  = '{32'h3FC00000, 32'h3F800001, RND_TIE,      3'b000};
        vecs[6]  = '{32'h3F800001, 32'h3FFFFFFE, RND_CARRY,    3'b000};
        vecs[7]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000};
        vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b100};
        vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
        vecs[10] = '{32'h80000001, 32'h3F800000, 32'h80000000, 3'b000};
        vecs[11] = '{32'hBF800000, 32'hBF800000, 32'h3F800000, 3'b000};

        #3;
        chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 0);
        chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 1);
        chk(out_p == 32'h0, "rst_out_p", 64'(out_p), 0);
        chk(out_tag == 4'h0, "rst_out_tag", 64'(out_tag), 0);
        chk(out_flags == 3'b000, "rst_out_flags", 64'(out_flags), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            chk(model(vecs[i].a, vecs[i].b) == {vecs[i].p, vecs[i].f},
                $sformatf("model_pin%0d", i), 64'(model(vecs[i].a, vecs[i].b)),
                {29'h0, vecs[i].p, vecs[i].f});
            run_one(vecs[i], 4'(i), $sformatf("vec%0d", i));
        end

        base = accepts;
        push_ops(0, 12, 16'hFFFF, 1'b0, 12, acc);
        chk(accepts - base == 12, "stream_one_per_cycle", 64'(accepts - base), 12);
        drain("stream_drain");

        got_tags.delete();
        out_ready = 1'b0;
        push_ops(0, 5, 16'h0000, 1'b0, 6, acc);
        chk(acc == 3, "stall_accepts", 64'(acc), 3);
        chk(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 0);
        chk(out_valid == 1'b1 && out_tag == 4'd0, "stall_head", {out_valid, out_tag}, 5'h10);
        out_ready = 1'b1;
        push_ops(3, 2, 16'hFFFF, 1'b0, 10, acc);
        chk(acc == 2, "release_accepts", 64'(acc), 2);
        drain("stall_drain");
        chk(got_tags.size() == 5, "stall_count", 64'(got_tags.size()), 5);
        for (int i = 0; i < 5 && i < got_tags.size(); i++)
            chk(got_tags[i] == 4'(i), $sformatf("stall_tag%0d", i), 64'(got_tags[i]), 64'(i));

        push_ops(0, 10, 16'b1010_0110_1100_1001, 1'b1, 80, acc);
        out_ready = 1'b1;
        chk(acc == 10, "pattern_accepts", 64'(acc), 10);
        drain("pattern_drain");

        in_valid = 1'b1; in_a = vecs[0].a; in_b = vecs[0].b; in_tag = 4'd1;
        @(posedge clk); #1;
        in_tag = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 0);
        chk(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 1);
        chk(out_p == 32'h0, "midrst_out_p", 64'(out_p), 0);
        chk(out_tag == 4'h0, "midrst_out_tag", 64'(out_tag), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk(stale == 0, "midrst_no_stale", 64'(stale), 0);
        run_one(vecs[7], 4'd9, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
